age_issue_queue: RTL and testbench

Age-ordered issue queue that owns its age matrix and feeds it to an oldest-first picker. The enqueue side allocates entries, records relative age, and accepts wakeups; the dequeue side issues the oldest valid-and-ready entry through a valid/ready handshake and frees it. It is the allocate/free end of the age-matrix/arbiter pair and is used wherever out-of-order issue with oldest-first priority is needed.

---
 rtl/age_issue_queue.sv | 143 ++++++++++++++
 tb/tb_age_issue_queue.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/age_issue_queue.sv
// Age-ordered issue queue: allocates entries into the lowest free slot,
// records relative age in a WIDTH x WIDTH matrix, accepts per-slot wakeups
// and issues the oldest valid-and-ready entry through a valid/ready handshake.
module age_issue_queue #(
  parameter int WIDTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enq_vld,
  output logic                       enq_rdy,
  input  logic [DATA_W-1:0]          enq_data,
  input  logic                       enq_ready_now,
  input  logic [WIDTH-1:0]           v_wake,
  output logic                       deq_vld,
  input  logic                       deq_rdy,
  output logic [DATA_W-1:0]          deq_data,
  output logic [$clog2(WIDTH)-1:0]   deq_idx,
  output logic [$clog2(WIDTH)-1:0]   alloc_idx,
  output logic [$clog2(WIDTH):0]     count
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = IDX_W + 1;

  // age_q[i][j] = 1 means slot i holds an older entry than slot j
  logic [WIDTH-1:0]             valid_q, valid_d;
  logic [WIDTH-1:0]             ready_q, ready_d;
  logic [WIDTH-1:0][DATA_W-1:0] data_q, data_d;
  logic [WIDTH-1:0][WIDTH-1:0]  age_q, age_d;
  logic [CNT_W-1:0]             count_q, count_d;

  logic [WIDTH-1:0]  elig_s;
  logic [WIDTH-1:0]  sel_s;
  logic [IDX_W-1:0]  sel_idx_s;
  logic [DATA_W-1:0] sel_data_s;
  logic [IDX_W-1:0]  alloc_idx_s;
  logic              enq_fire_s;
  logic              deq_fire_s;

  // Oldest-first pick: an eligible slot wins when no other eligible slot is older
  always_comb begin
    logic blocked;
    elig_s = valid_q & ready_q;
    sel_s  = '0;
    for (int s = 0; s < WIDTH; s++) begin
      blocked = 1'b0;
      for (int j = 0; j < WIDTH; j++) begin
        blocked = blocked | (elig_s[j] & age_q[j][s]);
      end
      sel_s[s] = elig_s[s] & ~blocked;
    end
  end

  // Encode the (one-hot) winner into index and payload, zero when nothing eligible
  always_comb begin
    logic found;
    found      = 1'b0;
    sel_idx_s  = '0;
    sel_data_s = '0;
    for (int s = 0; s < WIDTH; s++) begin
      if (sel_s[s] && !found) begin
        found      = 1'b1;
        sel_idx_s  = IDX_W'(s);
        sel_data_s = data_q[s];
      end else begin
        found = found;
      end
    end
  end

  // Lowest-index free slot from registered state, zero when the queue is full
  always_comb begin
    logic found;
    found       = 1'b0;
    alloc_idx_s = '0;
    for (int s = 0; s < WIDTH; s++) begin
      if (!valid_q[s] && !found) begin
        found       = 1'b1;
        alloc_idx_s = IDX_W'(s);
      end else begin
        found = found;
      end
    end
  end

  assign enq_rdy    = rst_n && (count_q != CNT_W'(WIDTH));
  assign deq_vld    = |elig_s;
  assign deq_data   = sel_data_s;
  assign deq_idx    = sel_idx_s;
  assign alloc_idx  = alloc_idx_s;
  assign count      = count_q;
  assign enq_fire_s = enq_vld && enq_rdy;
  assign deq_fire_s = deq_vld && deq_rdy && rst_n;

  // Next state: wake, free the issued slot, then fill the allocated slot as youngest
  always_comb begin
    valid_d = valid_q;
    ready_d = ready_q | (v_wake & valid_q);
    data_d  = data_q;
    age_d   = age_q;
    count_d = count_q + CNT_W'(enq_fire_s) - CNT_W'(deq_fire_s);
    if (deq_fire_s) begin
      valid_d[sel_idx_s] = 1'b0;
      ready_d[sel_idx_s] = 1'b0;
    end else begin
      valid_d = valid_d;
    end
    if (enq_fire_s) begin
      valid_d[alloc_idx_s] = 1'b1;
      ready_d[alloc_idx_s] = enq_ready_now | v_wake[alloc_idx_s];
      data_d[alloc_idx_s]  = enq_data;
      age_d[alloc_idx_s]   = '0;
      for (int j = 0; j < WIDTH; j++) begin
        if (IDX_W'(j) != alloc_idx_s) begin
          age_d[j][alloc_idx_s] = valid_q[j];
        end else begin
          age_d[j][alloc_idx_s] = 1'b0;
        end
      end
    end else begin
      valid_d = valid_d;
    end
  end

  // State registers with synchronous active-low reset discarding every entry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      ready_q <= '0;
      data_q  <= '0;
      age_q   <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      ready_q <= ready_d;
      data_q  <= data_d;
      age_q   <= age_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_age_issue_queue.sv
// Self-checking bench for age_issue_queue: a timestamp-based reference model
// checks every output each cycle, and a scoreboard queue holds the expected
// issue order (slot, payload) that is popped whenever a dequeue fires.
module tb_age_issue_queue;

  localparam int W = 4;
  localparam int D = 8;

  logic         clk;
  logic         rst_n;
  logic         enq_vld;
  logic         enq_rdy;
  logic [D-1:0] enq_data;
  logic         enq_ready_now;
  logic [W-1:0] v_wake;
  logic         deq_vld;
  logic         deq_rdy;
  logic [D-1:0] deq_data;
  logic [1:0]   deq_idx;
  logic [1:0]   alloc_idx;
  logic [2:0]   count;

  age_issue_queue #(.WIDTH(W), .DATA_W(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .enq_vld(enq_vld), .enq_rdy(enq_rdy), .enq_data(enq_data),
    .enq_ready_now(enq_ready_now), .v_wake(v_wake),
    .deq_vld(deq_vld), .deq_rdy(deq_rdy), .deq_data(deq_data),
    .deq_idx(deq_idx), .alloc_idx(alloc_idx), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: per-slot state plus an allocation timestamp for age
  bit         m_valid [W];
  bit         m_ready [W];
  logic [7:0] m_data  [W];
  int         m_stamp [W];
  int         stamp_ctr = 0;
  bit         sb_auto = 1'b0;
  logic [9:0] sb_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < W; i++) c += m_valid[i];
    return c;
  endfunction

  function automatic int m_alloc();
    for (int i = 0; i < W; i++) if (!m_valid[i]) return i;
    return 0;
  endfunction

  function automatic int m_sel();
    int best = -1;
    for (int i = 0; i < W; i++)
      if (m_valid[i] && m_ready[i] && (best < 0 || m_stamp[i] < m_stamp[best])) best = i;
    return best;
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < W; i++) begin
      m_valid[i] = 1'b0; m_ready[i] = 1'b0; m_data[i] = 8'h00; m_stamp[i] = 0;
    end
  endfunction

  // one clock: check outputs against the model, score any dequeue, advance the model
  task automatic step();
    int s, a;
    bit ef, df;
    logic [9:0] e;
    #1;
    s  = m_sel();
    a  = m_alloc();
    check_eq("enq_rdy",   enq_rdy,   (rst_n && m_count() != W));
    check_eq("deq_vld",   deq_vld,   (s >= 0));
    check_eq("deq_idx",   deq_idx,   (s >= 0) ? s : 0);
    check_eq("deq_data",  deq_data,  (s >= 0) ? m_data[s] : 8'h00);
    check_eq("alloc_idx", alloc_idx, a);
    check_eq("count",     count,     m_count());
    ef = rst_n && enq_vld && (m_count() != W);
    df = rst_n && deq_rdy && (s >= 0);
    if (df) begin
      if (sb_auto) sb_q.push_back({s[1:0], m_data[s]});
      check_eq("sb_avail", (sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check_eq("sb_idx",  deq_idx,  e[9:8]);
        check_eq("sb_data", deq_data, e[7:0]);
      end
    end
    @(posedge clk);
    if (!rst_n) begin
      m_clear();
    end else begin
      for (int i = 0; i < W; i++) if (m_valid[i] && v_wake[i]) m_ready[i] = 1'b1;
      if (df) begin m_valid[s] = 1'b0; m_ready[s] = 1'b0; end
      if (ef) begin
        m_valid[a] = 1'b1;
        m_ready[a] = enq_ready_now | v_wake[a];
        m_data[a]  = enq_data;
        m_stamp[a] = stamp_ctr++;
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic ev, input logic [7:0] d, input logic rn,
                       input logic [3:0] w, input logic dr);
    enq_vld = ev; enq_data = d; enq_ready_now = rn; v_wake = w; deq_rdy = dr;
    step();
  endtask

  task automatic push(input logic [1:0] idx, input logic [7:0] d);
    sb_q.push_back({idx, d});
  endtask

  initial begin
    m_clear();
    rst_n = 1'b0; enq_vld = 1'b0; enq_data = 8'h00; enq_ready_now = 1'b0;
    v_wake = 4'h0; deq_rdy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rst_enq_rdy", enq_rdy, 1);
    check_eq("rst_deq_vld", deq_vld, 0);
    check_eq("rst_count",   count,   0);

    // fill with four ready entries, then drain in age order
    drive(1'b1, 8'h11, 1'b1, 4'h0, 1'b0);
    drive(1'b1, 8'h22, 1'b1, 4'h0, 1'b0);
    drive(1'b1, 8'h33, 1'b1, 4'h0, 1'b0);
    drive(1'b1, 8'h44, 1'b1, 4'h0, 1'b0);
    #1;
    check_eq("full_count",    count,    4);
    check_eq("full_enq_rdy",  enq_rdy,  0);
    check_eq("full_deq_idx",  deq_idx,  0);
    check_eq("full_deq_data", deq_data, 8'h11);
    push(2'd0, 8'h11); push(2'd1, 8'h22); push(2'd2, 8'h33); push(2'd3, 8'h44);
    repeat (4) drive(1'b0, 8'h00, 1'b0, 4'h0, 1'b1);
    check_eq("drain_count", count, 0);

    // not-ready entries issue in wake order, oldest first among the ready ones
    drive(1'b1, 8'h11, 1'b0, 4'h0, 1'b0);
    drive(1'b1, 8'h22, 1'b0, 4'h0, 1'b0);
    drive(1'b1, 8'h33, 1'b0, 4'h0, 1'b0);
    push(2'd2, 8'h33); push(2'd0, 8'h11);
    drive(1'b0, 8'h00, 1'b0, 4'b0100, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 4'b0001, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 4'h0, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 4'h0, 1'b1);
    check_eq("unwoken_stays", count, 1);
    push(2'd1, 8'h22);
    drive(1'b0, 8'h00, 1'b0, 4'b0010, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 4'h0, 1'b1);

    // reuse of a freed middle slot: new entry is youngest
    drive(1'b1, 8'h11, 1'b0, 4'h0, 1'b0);
    drive(1'b1, 8'h22, 1'b0, 4'h0, 1'b0);
    drive(1'b1, 8'h33, 1'b0, 4'h0, 1'b0);
    drive(1'b1, 8'h44, 1'b0, 4'h0, 1'b0);
    push(2'd1, 8'h22);
    drive(1'b0, 8'h00, 1'b0, 4'b0010, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 4'h0, 1'b1);
    #1;
    check_eq("reuse_alloc", alloc_idx, 1);
    drive(1'b1, 8'h55, 1'b0, 4'h0, 1'b0);
    push(2'd0, 8'h11); push(2'd2, 8'h33); push(2'd3, 8'h44); push(2'd1, 8'h55);
    drive(1'b0, 8'h00, 1'b0, 4'hF, 1'b1);
    repeat (4) drive(1'b0, 8'h00, 1'b0, 4'h0, 1'b1);

    // simultaneous enqueue and dequeue at count 2
    drive(1'b1, 8'h66, 1'b1, 4'h0, 1'b0);
    drive(1'b1, 8'h77, 1'b1, 4'h0, 1'b0);
    push(2'd0, 8'h66);
    drive(1'b1, 8'h88, 1'b1, 4'h0, 1'b1);
    check_eq("simul_count", count, 2);
    push(2'd1, 8'h77); push(2'd2, 8'h88);
    repeat (2) drive(1'b0, 8'h00, 1'b0, 4'h0, 1'b1);

    // reset mid-operation discards entries; enqueue during reset ignored
    drive(1'b1, 8'hA1, 1'b1, 4'h0, 1'b0);
    drive(1'b1, 8'hA2, 1'b1, 4'h0, 1'b0);
    drive(1'b1, 8'hA3, 1'b1, 4'h0, 1'b0);
    rst_n = 1'b0;
    drive(1'b1, 8'h99, 1'b1, 4'h0, 1'b1);
    rst_n = 1'b1;
    #1;
    check_eq("midrst_count",   count,   0);
    check_eq("midrst_deq_vld", deq_vld, 0);
    drive(1'b0, 8'h00, 1'b0, 4'h0, 1'b0);

    // random traffic against the model, with occasional resets
    sb_auto = 1'b1;
    for (int k = 0; k < 400; k++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      drive($urandom_range(0, 2) != 0, 8'($urandom_range(0, 255)), $urandom_range(0, 1) == 1,
            ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0,
            $urandom_range(0, 2) != 0);
    end
    rst_n = 1'b1;
    repeat (8) drive(1'b0, 8'h00, 1'b0, 4'hF, 1'b1);
    check_eq("end_count",  count,        0);
    check_eq("sb_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
